// File: rtl/layer_stream_serializer_pkg.sv
// Shared definitions for the layer stream serializer: default datapath
// width, per-layer neuron counts and the serializer state encodings.
package layer_stream_serializer_pkg;

    localparam int dataWidth       = 16;

    localparam int numNeuronLayer1 = 30;
    localparam int numNeuronLayer2 = 30;
    localparam int numNeuronLayer3 = 10;
    localparam int numNeuronLayer4 = 10;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // Index width for an n-beat frame, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_argmax.sv
// Running signed argmax over the beats of one frame; reports the winning
// index/value with a one-cycle pulse after the last beat is handed off.
module stream_argmax
    import layer_stream_serializer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NN     = 30,
    localparam int IDX_W = idx_width(NN)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              beat_valid,
    input  logic [IDX_W-1:0]  beat_idx,
    input  logic [DATA_W-1:0] beat_data,
    input  logic              beat_last,
    output logic              max_valid,
    output logic [IDX_W-1:0]  max_idx,
    output logic [DATA_W-1:0] max_val
);

    logic [DATA_W-1:0] run_val;
    logic [IDX_W-1:0]  run_idx;
    logic              take;
    logic [DATA_W-1:0] next_val;
    logic [IDX_W-1:0]  next_idx;

    // Beat 0 seeds the maximum; later beats win only on strict signed >.
    always_comb begin
        take     = (beat_idx == '0) || ($signed(beat_data) > $signed(run_val));
        next_val = take ? beat_data : run_val;
        next_idx = take ? beat_idx  : run_idx;
    end

    // Track the running maximum and publish it when the frame completes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            run_val   <= '0;
            run_idx   <= '0;
            max_valid <= 1'b0;
            max_idx   <= '0;
            max_val   <= '0;
        end else begin
            max_valid <= 1'b0;
            if (beat_valid) begin
                run_val <= next_val;
                run_idx <= next_idx;
                if (beat_last) begin
                    max_valid <= 1'b1;
                    max_idx   <= next_idx;
                    max_val   <= next_val;
                end
            end
        end
    end

endmodule

// File: rtl/layer_stream_serializer.sv
// Parallel-to-serial converter between network layers: captures a packed
// NN-neuron vector and emits one neuron per beat on a valid/ready stream,
// with an optional pending vector register and optional argmax.
module layer_stream_serializer
    import layer_stream_serializer_pkg::*;
#(
    parameter int NN        = numNeuronLayer1,
    parameter int DATA_W    = dataWidth,
    parameter int DBUF      = 1,
    parameter int ARGMAX_EN = 0,
    localparam int IDX_W    = idx_width(NN)
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    input  logic                 in_valid,
    input  logic [NN*DATA_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_last,
    output logic                 max_valid,
    output logic [IDX_W-1:0]     max_idx,
    output logic [DATA_W-1:0]    max_val,
    output logic                 drop_pulse,
    output logic                 drop_flag
);

    logic [0:0]           state;
    logic [NN*DATA_W-1:0] shreg;
    logic [NN*DATA_W-1:0] pend_data;
    logic                 pend_full;
    logic [IDX_W-1:0]     idx_q;

    logic beat_hs;
    logic last_hs;
    logic accept;
    logic load_direct;
    logic load_pend;
    logic to_pend;

    assign out_valid = (state == SEND);
    assign out_data  = shreg[DATA_W-1:0];
    assign out_idx   = idx_q;
    assign out_last  = out_valid && (idx_q == IDX_W'(NN - 1));

    // Handshake decode and routing of an accepted vector.
    // Without the pending register the only free slot mid-frame is the
    // last-beat handshake, so in_ready depends combinationally on out_ready.
    always_comb begin
        beat_hs = out_valid && out_ready;
        last_hs = beat_hs && out_last;
        if (DBUF != 0) begin
            in_ready = !pend_full;
        end else begin
            in_ready = (state == IDLE) || last_hs;
        end
        accept      = in_valid && in_ready;
        load_direct = accept && ((state == IDLE) || (last_hs && !pend_full));
        load_pend   = last_hs && pend_full;
        to_pend     = (DBUF != 0) && accept && !load_direct;
    end

    // Shift register, beat index, state and pending vector.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state     <= IDLE;
            shreg     <= '0;
            idx_q     <= '0;
            pend_data <= '0;
            pend_full <= 1'b0;
        end else begin
            if (load_direct) begin
                shreg <= in_data;
                idx_q <= '0;
                state <= SEND;
            end else if (load_pend) begin
                shreg     <= pend_data;
                idx_q     <= '0;
                pend_full <= 1'b0;
            end else if (last_hs) begin
                shreg <= shreg >> DATA_W;
                idx_q <= '0;
                state <= IDLE;
            end else if (beat_hs) begin
                shreg <= shreg >> DATA_W;
                idx_q <= idx_q + IDX_W'(1);
            end
            if (to_pend) begin
                pend_data <= in_data;
                pend_full <= 1'b1;
            end
        end
    end

    // Report vectors offered while no slot was free.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            drop_pulse <= 1'b0;
            drop_flag  <= 1'b0;
        end else begin
            drop_pulse <= in_valid && !in_ready;
            if (in_valid && !in_ready) begin
                drop_flag <= 1'b1;
            end
        end
    end

    generate
        if (ARGMAX_EN != 0) begin : g_argmax
            stream_argmax #(
                .DATA_W (DATA_W),
                .NN     (NN)
            ) u_argmax (
                .clk        (s_axi_aclk),
                .rstn       (s_axi_aresetn),
                .beat_valid (beat_hs),
                .beat_idx   (idx_q),
                .beat_data  (shreg[DATA_W-1:0]),
                .beat_last  (out_last),
                .max_valid  (max_valid),
                .max_idx    (max_idx),
                .max_val    (max_val)
            );
        end else begin : g_no_argmax
            assign max_valid = 1'b0;
            assign max_idx   = '0;
            assign max_val   = '0;
        end
    endgenerate

endmodule

// File: tb/tb_layer_stream_serializer.sv
// Self-checking bench for layer_stream_serializer (NN=4, DATA_W=8, DBUF=1,
// ARGMAX_EN=1) against a queue-based reference model of the beat stream.
module tb_layer_stream_serializer;

    localparam int NN = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic [1:0]    out_idx;
    logic          out_last;
    logic          max_valid;
    logic [1:0]    max_idx;
    logic [7:0]    max_val;
    logic          drop_pulse;
    logic          drop_flag;

    int checks = 0;
    int failures = 0;

    layer_stream_serializer #(
        .NN        (NN),
        .DATA_W    (DW),
        .DBUF      (1),
        .ARGMAX_EN (1)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rstn),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_idx       (out_idx),
        .out_last      (out_last),
        .max_valid     (max_valid),
        .max_idx       (max_idx),
        .max_val       (max_val),
        .drop_pulse    (drop_pulse),
        .drop_flag     (drop_flag)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    beat_t      beatq[$];
    logic [1:0] maxq_idx[$];
    logic [7:0] maxq_val[$];
    int         outstanding = 0;   // accepted vectors whose last beat has not been taken
    bit         max_pend = 0;
    logic [1:0] max_pend_idx;
    logic [7:0] max_pend_val;
    bit         drop_exp = 0;
    bit         flag_exp = 0;
    beat_t      mon_b;
    logic [1:0] mon_mi;

    // Signed argmax with lowest index winning ties.
    function automatic logic [1:0] ref_argmax(input logic [31:0] v);
        int best = 0;
        for (int k = 1; k < NN; k++)
            if ($signed(v[k*DW +: DW]) > $signed(v[best*DW +: DW])) best = k;
        return 2'(best);
    endfunction

    // Monitor: sample mid-cycle, compare against the model, then advance it.
    always @(negedge clk) begin
        if (!rstn) begin
            beatq.delete();
            maxq_idx.delete();
            maxq_val.delete();
            outstanding = 0;
            max_pend = 0;
            drop_exp = 0;
            flag_exp = 0;
        end else begin
            checks++;
            if (out_valid !== (beatq.size() != 0)) begin
                failures++;
                $display("FAIL mon_out_valid got=%b exp=%b t=%0t", out_valid, beatq.size() != 0, $time);
            end
            checks++;
            if (drop_pulse !== drop_exp || drop_flag !== flag_exp) begin
                failures++;
                $display("FAIL mon_drop got=%b/%b exp=%b/%b t=%0t", drop_pulse, drop_flag, drop_exp, flag_exp, $time);
            end
            checks++;
            if (max_valid !== max_pend) begin
                failures++;
                $display("FAIL mon_max_valid got=%b exp=%b t=%0t", max_valid, max_pend, $time);
            end else if (max_pend) begin
                checks++;
                if (max_idx !== max_pend_idx || max_val !== max_pend_val) begin
                    failures++;
                    $display("FAIL mon_max got=%0d/%h exp=%0d/%h t=%0t", max_idx, max_val, max_pend_idx, max_pend_val, $time);
                end
            end
            max_pend = 0;
            drop_exp = 0;
            if (in_valid) begin
                checks++;
                if (in_ready !== (outstanding < 2)) begin
                    failures++;
                    $display("FAIL mon_in_ready got=%b exp=%b t=%0t", in_ready, outstanding < 2, $time);
                end
            end
            if (out_valid && out_ready && beatq.size() != 0) begin
                mon_b = beatq.pop_front();
                checks++;
                if (out_data !== mon_b.data || out_idx !== mon_b.idx || out_last !== mon_b.last) begin
                    failures++;
                    $display("FAIL mon_beat got=%h/%0d/%b exp=%h/%0d/%b t=%0t", out_data, out_idx, out_last, mon_b.data, mon_b.idx, mon_b.last, $time);
                end
                if (mon_b.last) begin
                    max_pend = 1;
                    max_pend_idx = maxq_idx.pop_front();
                    max_pend_val = maxq_val.pop_front();
                    outstanding--;
                end
            end
            if (in_valid) begin
                if (in_ready === 1'b1) begin
                    for (int k = 0; k < NN; k++) begin
                        mon_b.data = in_data[k*DW +: DW];
                        mon_b.idx  = 2'(k);
                        mon_b.last = (k == NN - 1);
                        beatq.push_back(mon_b);
                    end
                    mon_mi = ref_argmax(in_data);
                    maxq_idx.push_back(mon_mi);
                    maxq_val.push_back(in_data[mon_mi*DW +: DW]);
                    outstanding++;
                end else begin
                    drop_exp = 1;
                    flag_exp = 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] v);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (beatq.size() == 0 && !max_pend) begin
                ok = 1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, out_idx, out_data, max_valid, max_idx, max_val, drop_pulse, drop_flag} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b l=%b i=%0d d=%h mv=%b mi=%0d mx=%h dp=%b df=%b exp all 0",
                     out_valid, out_last, out_idx, out_data, max_valid, max_idx, max_val, drop_pulse, drop_flag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [4];
        bit ok;
        exp_d = '{8'h05, 8'hFE, 8'h7F, 8'h10};
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {8'h10, 8'h7F, 8'hFE, 8'h05};
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_idx !== 2'(k) || out_last !== (k == 3)) begin
                failures++;
                $display("FAIL basic_beat%0d got=%b/%h/%0d/%b exp=1/%h/%0d/%b", k, out_valid, out_data, out_idx, out_last, exp_d[k], k, k == 3);
            end
        end
        @(negedge clk);
        checks++;
        if (max_valid !== 1'b1 || max_idx !== 2'd2 || max_val !== 8'h7F || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_max got=%b/%0d/%h ov=%b exp=1/2/7f ov=0", max_valid, max_idx, max_val, out_valid);
        end
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_drain got=timeout exp=drained"); end
    endtask

    task automatic test_backpressure();
        logic [6:0]  pat = 7'b1011001;
        logic [31:0] v = $urandom;
        logic [7:0]  prev_d = '0;
        logic [1:0]  prev_i = '0;
        bit          prev_stall = 0;
        int          hs = 0;
        bit          ok;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (out_data !== prev_d || out_idx !== prev_i || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_hold got=%h/%0d exp=%h/%0d", out_data, out_idx, prev_d, prev_i);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== v[hs*DW +: DW] || out_idx !== 2'(hs)) begin
                    failures++;
                    $display("FAIL bp_beat got=%h/%0d exp=%h/%0d", out_data, out_idx, v[hs*DW +: DW], hs);
                end
                hs++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_i = out_idx;
            @(posedge clk); #1;
        end
        checks++;
        if (hs != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", hs); end
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_drain got=timeout exp=drained"); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v1 = $urandom;
        bit ok;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_last !== (b % 4 == 3) || out_idx !== 2'(b % 4)) begin
                failures++;
                $display("FAIL b2b_beat%0d got=%b/%b/%0d exp=1/%b/%0d", b, out_valid, out_last, out_idx, b % 4 == 3, b % 4);
            end
            @(posedge clk); #1;
            if (b == 0) begin
                in_valid = 1'b1;
                in_data  = {8'd4, 8'd3, 8'd2, 8'd1};
            end else if (b == 1) begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (max_valid !== 1'b1 || max_idx !== 2'd3 || max_val !== 8'd4) begin
            failures++;
            $display("FAIL b2b_max2 got=%b/%0d/%h exp=1/3/04", max_valid, max_idx, max_val);
        end
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_drain got=timeout exp=drained"); end
    endtask

    task automatic test_overflow();
        bit ok;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = $urandom;
            @(negedge clk);
            checks++;
            if (in_ready !== (n < 2)) begin
                failures++;
                $display("FAIL ovf_in_ready%0d got=%b exp=%b", n, in_ready, n < 2);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (drop_pulse !== 1'b1 || drop_flag !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drop got=%b/%b exp=1/1", drop_pulse, drop_flag);
        end
        @(negedge clk);
        checks++;
        if (drop_pulse !== 1'b0 || drop_flag !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drop_after got=%b/%b exp=0/1", drop_pulse, drop_flag);
        end
        drain(ok);
        checks++;
        if (!ok || drop_flag !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drain got=%b/%b exp=1/1", ok, drop_flag);
        end
    endtask

    task automatic test_ties();
        bit ok;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send({8'h81, 8'hF0, 8'hF0, 8'h80});
        drain(ok);
        checks++;
        if (!ok || max_idx !== 2'd1 || max_val !== 8'hF0) begin
            failures++;
            $display("FAIL ties_max got=%b/%0d/%h exp=1/1/f0", ok, max_idx, max_val);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v = $urandom;
        logic [1:0]  mi;
        bit ok;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = $urandom;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, out_idx, out_data, max_valid, max_idx, max_val, drop_pulse, drop_flag} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got v=%b l=%b i=%0d d=%h mv=%b mi=%0d mx=%h dp=%b df=%b exp all 0",
                     out_valid, out_last, out_idx, out_data, max_valid, max_idx, max_val, drop_pulse, drop_flag);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (max_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_max got=%b exp=0", max_valid); end
        end
        send(v);
        drain(ok);
        mi = ref_argmax(v);
        checks++;
        if (!ok || max_idx !== mi || max_val !== v[mi*DW +: DW]) begin
            failures++;
            $display("FAIL rstmid_after got=%b/%0d/%h exp=1/%0d/%h", ok, max_idx, max_val, mi, v[mi*DW +: DW]);
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) == 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL random_drain got=timeout exp=drained"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_ties();
        test_reset_midframe();
        test_random();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
